melody_seq: RTL and testbench

//  Note sequencer feeding the buzzer tone generator: steps through a fixed 8-entry note ROM.

---
 rtl/melody_seq.sv | 138 +++++++++++++
 tb/tb_melody_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/melody_seq.sv
// Note sequencer: walks an 8-entry note ROM and drives note_div/note_on to the buzzer tone stage.
// Optional build macro LOOP_EN: replay the melody forever instead of stopping after note 7.
module melody_seq #(
    parameter int TICK_DIV = 1200000,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic [DIV_W-1:0] note_div,
    output logic             note_on,
    output logic [2:0]       note_idx,
    output logic             busy,
    output logic             done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               done_q, done_d;

    function automatic logic [DIV_W-1:0] rom_div(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_div = DIV_W'(11472);
            3'd1:    rom_div = DIV_W'(10220);
            3'd2:    rom_div = DIV_W'(9105);
            3'd3:    rom_div = '0;
            3'd4:    rom_div = DIV_W'(8594);
            3'd5:    rom_div = DIV_W'(7656);
            3'd6:    rom_div = DIV_W'(6820);
            default: rom_div = DIV_W'(5736);
        endcase
    endfunction

    function automatic logic [DUR_W-1:0] rom_dur(input logic [2:0] idx);
        case (idx)
            3'd3:    rom_dur = DUR_W'(1);
            3'd7:    rom_dur = DUR_W'(4);
            default: rom_dur = DUR_W'(2);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                div_d   = rom_div(idx_q);
                dur_d   = (rom_dur(idx_q) == '0) ? DUR_W'(1) : rom_dur(idx_q);
                tick_d  = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    dur_d  = dur_q - DUR_W'(1);
                    if (dur_q == DUR_W'(1)) state_d = S_GAP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef LOOP_EN
                        idx_d   = '0;
                        state_d = S_LOAD;
`else
                        idx_d   = '0;
                        div_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
        endcase
        // Abort wins over everything above and never produces a done pulse.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            div_d   = '0;
            idx_d   = '0;
            tick_d  = '0;
            dur_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    assign note_div = div_q;
    assign note_on  = (state_q == S_PLAY) && (div_q != '0);
    assign note_idx = idx_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq (TICK_DIV=4): expected per-cycle outputs are built from the note
// schedule into a scoreboard queue and popped one entry per clock.
module tb_melody_seq;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] note_div;
    logic        note_on;
    logic [2:0]  note_idx;
    logic        busy, done;

    always #5 clk = ~clk;

    melody_seq #(.TICK_DIV(4), .DIV_W(16), .DUR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .note_div(note_div), .note_on(note_on), .note_idx(note_idx),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic        on;
        logic [15:0] div;
        logic [2:0]  idx;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] rdiv[8] = '{16'd11472, 16'd10220, 16'd9105, 16'd0,
                             16'd8594, 16'd7656, 16'd6820, 16'd5736};
    int          rdur[8] = '{2, 2, 2, 1, 2, 2, 2, 4};

    task automatic push(input logic on, input logic [15:0] div, input logic [2:0] idx,
                        input logic bsy, input logic dn);
        exp_t e;
        e.on = on; e.div = div; e.idx = idx; e.busy = bsy; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic push_idle(input logic dn);
        push(1'b0, 16'd0, 3'd0, 1'b0, dn);
    endtask

    // Cycles 1..110 after a start pulse: per note LOAD, dur*4 PLAY, 4 GAP; then the end behaviour.
    task automatic push_run();
        logic [15:0] prev;
        prev = 16'd0;
        for (int i = 0; i < 8; i++) begin
            push(1'b0, prev, 3'(i), 1'b1, 1'b0);
            for (int k = 0; k < rdur[i] * 4; k++) push(rdiv[i] != 16'd0, rdiv[i], 3'(i), 1'b1, 1'b0);
            for (int k = 0; k < 4; k++) push(1'b0, rdiv[i], 3'(i), 1'b1, 1'b0);
            prev = rdiv[i];
        end
`ifdef LOOP_EN
        push(1'b0, 16'd5736, 3'd0, 1'b1, 1'b0);
`else
        push_idle(1'b1);
`endif
        push_idle(1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (note_on === e.on) else begin
                errors++; $error("FAIL %s note_on obs=%0b exp=%0b", tag, note_on, e.on);
            end
            checks++;
            assert (note_div === e.div) else begin
                errors++; $error("FAIL %s note_div obs=%0d exp=%0d", tag, note_div, e.div);
            end
            checks++;
            assert (note_idx === e.idx) else begin
                errors++; $error("FAIL %s note_idx obs=%0d exp=%0d", tag, note_idx, e.idx);
            end
            checks++;
            assert (busy === e.busy) else begin
                errors++; $error("FAIL %s busy obs=%0b exp=%0b", tag, busy, e.busy);
            end
            checks++;
            assert (done === e.done) else begin
                errors++; $error("FAIL %s done obs=%0b exp=%0b", tag, done, e.done);
            end
        end
    endtask

    // Start has already been driven for cycle 0; stop is raised at 109 to leave LOOP_EN builds idle.
    task automatic run_melody(input string name, input int repulse_at);
        for (int c = 1; c <= 110; c++) begin
            step();
            chk_cycle($sformatf("%s_c%0d", name, c));
            start = (c == repulse_at);
            stop  = (c == 109);
        end
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0;
        step();
        step();
        push_idle(1'b0);
        chk_cycle("reset");
        rst = 1'b0; start = 1'b0;
        step();
        push_idle(1'b0);
        chk_cycle("post_reset");

        // Full melody, with a start re-pulse mid-run that must not disturb timing.
        start = 1'b1;
        push_run();
        run_melody("full", 20);

        // start and stop together in IDLE keep the block idle.
        start = 1'b1; stop = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            push_idle(1'b0);
            chk_cycle($sformatf("start_stop_c%0d", c));
            start = 1'b0; stop = 1'b0;
        end

        // Abort mid note 0, then restart from idx 0.
        start = 1'b1;
        push_run();
        for (int c = 1; c <= 5; c++) begin
            step();
            chk_cycle($sformatf("abort_c%0d", c));
            start = 1'b0;
        end
        stop = 1'b1;
        sb.delete();
        for (int c = 6; c <= 10; c++) begin
            step();
            stop = 1'b0;
            push_idle(1'b0);
            chk_cycle($sformatf("abort_c%0d", c));
        end
        start = 1'b1;
        push_run();
        run_melody("replay", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
